// File: rtl/sliding_window_3x3_8bits.sv
// 3x3 sliding window generator over a raster-order 8-bit pixel stream.
// Two line buffers feed a 3x3 register window; all outputs are registered.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   frame_start    restarts the frame; a same-cycle valid pixel is (0,0)
//   pixel_valid    pixel_in is accepted this cycle
//   pixel_in       8-bit unsigned pixel, raster order
//   window_valid   pixel0..pixel8 hold a complete 3x3 window
//   pixel0..8      window, row-major, oldest row and column first
//   frame_done     one-cycle pulse alongside the last window of a frame
module sliding_window_3x3_8bits #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       pixel_valid,
   input  logic [7:0] pixel_in,
   output logic       window_valid,
   output logic [7:0] pixel0,
   output logic [7:0] pixel1,
   output logic [7:0] pixel2,
   output logic [7:0] pixel3,
   output logic [7:0] pixel4,
   output logic [7:0] pixel5,
   output logic [7:0] pixel6,
   output logic [7:0] pixel7,
   output logic [7:0] pixel8,
   output logic       frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;

   logic [7:0] lb0 [IMG_WIDTH];
   logic [7:0] lb1 [IMG_WIDTH];
   logic [7:0] tap0;
   logic [7:0] tap1;

   logic last_col;
   logic last_row;
   logic win_ok;

   logic [7:0] win [9];
   logic       win_valid_q;
   logic       frame_done_q;

   // frame_start overrides the stored position before the pixel is placed,
   // so everything below works on the effective (cur_row, cur_col).
   always_comb begin
      cur_col = col;
      cur_row = row;
      if (frame_start) begin
         cur_col = '0;
         cur_row = '0;
      end
   end

   // Line buffer taps are read before this cycle's write lands.
   always_comb begin
      tap0 = lb0[cur_col];
      tap1 = lb1[cur_col];
   end

   always_comb begin
      last_col = (cur_col == COL_LAST);
      last_row = (cur_row == ROW_LAST);
      win_ok   = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (pixel_valid) begin
         if (last_col) begin
            col <= '0;
            if (last_row) begin
               row <= '0;
            end else begin
               row <= cur_row + 1'b1;
            end
         end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
         end
      end else if (frame_start) begin
         col <= '0;
         row <= '0;
      end
   end

   // Line buffers carry no reset; stale contents only ever reach columns
   // or rows that are never flagged valid.
   always_ff @(posedge clk) begin
      if (rst_n && pixel_valid) begin
         lb1[cur_col] <= tap0;
         lb0[cur_col] <= pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) begin
            win[i] <= '0;
         end
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         win_valid_q  <= pixel_valid && win_ok;
         frame_done_q <= pixel_valid && last_col && last_row;
         if (pixel_valid) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= tap1;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= tap0;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= pixel_in;
         end
      end
   end

   assign window_valid = win_valid_q;
   assign frame_done   = frame_done_q;
   assign pixel0       = win[0];
   assign pixel1       = win[1];
   assign pixel2       = win[2];
   assign pixel3       = win[3];
   assign pixel4       = win[4];
   assign pixel5       = win[5];
   assign pixel6       = win[6];
   assign pixel7       = win[7];
   assign pixel8       = win[8];

endmodule

// File: tb/tb_sliding_window_3x3_8bits.sv
// Scoreboard bench for sliding_window_3x3_8bits.
// Drives a 4x4 instance and a 3x3 instance with directed frames.
module tb_sliding_window_3x3_8bits;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_fs  = 1'b0;
   logic       a_v   = 1'b0;
   logic [7:0] a_pix = 8'h00;
   logic       a_wv;
   logic       a_fd;
   logic [7:0] a_p [9];
   logic [71:0] a_win;

   logic       b_fs  = 1'b0;
   logic       b_v   = 1'b0;
   logic [7:0] b_pix = 8'h00;
   logic       b_wv;
   logic       b_fd;
   logic [7:0] b_p [9];
   logic [71:0] b_win;

   assign a_win = {a_p[0], a_p[1], a_p[2], a_p[3], a_p[4],
                   a_p[5], a_p[6], a_p[7], a_p[8]};
   assign b_win = {b_p[0], b_p[1], b_p[2], b_p[3], b_p[4],
                   b_p[5], b_p[6], b_p[7], b_p[8]};

   sliding_window_3x3_8bits #(
      .IMG_WIDTH(4),
      .IMG_HEIGHT(4)
   ) dut_a (
      .clk(clk),
      .rst_n(rst_n),
      .frame_start(a_fs),
      .pixel_valid(a_v),
      .pixel_in(a_pix),
      .window_valid(a_wv),
      .pixel0(a_p[0]),
      .pixel1(a_p[1]),
      .pixel2(a_p[2]),
      .pixel3(a_p[3]),
      .pixel4(a_p[4]),
      .pixel5(a_p[5]),
      .pixel6(a_p[6]),
      .pixel7(a_p[7]),
      .pixel8(a_p[8]),
      .frame_done(a_fd)
   );

   sliding_window_3x3_8bits #(
      .IMG_WIDTH(3),
      .IMG_HEIGHT(3)
   ) dut_b (
      .clk(clk),
      .rst_n(rst_n),
      .frame_start(b_fs),
      .pixel_valid(b_v),
      .pixel_in(b_pix),
      .window_valid(b_wv),
      .pixel0(b_p[0]),
      .pixel1(b_p[1]),
      .pixel2(b_p[2]),
      .pixel3(b_p[3]),
      .pixel4(b_p[4]),
      .pixel5(b_p[5]),
      .pixel6(b_p[6]),
      .pixel7(b_p[7]),
      .pixel8(b_p[8]),
      .frame_done(b_fd)
   );

   // Hand-written 4x4 windows for pixel value 16*row+col, in emit order.
   localparam logic [71:0] WT [4] = '{
      {8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22},
      {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23},
      {8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32},
      {8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33}
   };

   typedef struct packed {
      logic [71:0] w;
      logic        fd;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;

   int total = 0;
   int bad   = 0;
   int a_cnt = 0;
   int b_cnt = 0;

   task automatic chk(input string nm, input logic [71:0] act,
                      input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [71:0] addb(input logic [71:0] w,
                                        input logic [7:0] b);
      logic [71:0] r;
      for (int i = 0; i < 9; i++) begin
         r[8*i +: 8] = w[8*i +: 8] + b;
      end
      return r;
   endfunction

   task automatic push_a(input logic [71:0] w, input logic fd);
      exp_t e;
      e.w  = w;
      e.fd = fd;
      qa.push_back(e);
   endtask

   task automatic push_frame_a(input logic [7:0] base);
      for (int i = 0; i < 4; i++) begin
         push_a(addb(WT[i], base), i == 3);
      end
   endtask

   task automatic send_a(input logic v, input logic fs, input logic [7:0] p);
      a_v   = v;
      a_fs  = fs;
      a_pix = p;
      @(posedge clk);
      #1;
   endtask

   task automatic send_b(input logic v, input logic fs, input logic [7:0] p);
      b_v   = v;
      b_fs  = fs;
      b_pix = p;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a(input int n);
      for (int i = 0; i < n; i++) begin
         send_a(1'b0, 1'b0, 8'h00);
      end
   endtask

   // Full 4x4 frame; window_valid must rise exactly after pixel 10.
   task automatic frame_a(input logic [7:0] base, input logic fs,
                          input string tag);
      for (int k = 0; k < 16; k++) begin
         send_a(1'b1, fs && (k == 0), base + 8'(16 * (k / 4) + (k % 4)));
         if (k == 9) chk({tag, "_wv_before"}, 72'(a_wv), 72'(0));
         if (k == 10) chk({tag, "_wv_rise"}, 72'(a_wv), 72'(1));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      a_v   = 1'b0;
      a_fs  = 1'b0;
      b_v   = 1'b0;
      b_fs  = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (a_wv === 1'b1) begin
         a_cnt++;
         if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_extra_window got=%h want=none", a_win);
         end else begin
            ea = qa.pop_front();
            chk("a_window", a_win, ea.w);
            chk("a_frame_done", 72'(a_fd), 72'(ea.fd));
         end
      end else if (a_fd === 1'b1) begin
         total++;
         bad++;
         $display("FAIL a_lone_frame_done got=1 want=0");
      end
   end

   always @(negedge clk) begin
      if (b_wv === 1'b1) begin
         b_cnt++;
         if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_extra_window got=%h want=none", b_win);
         end else begin
            eb = qb.pop_front();
            chk("b_window", b_win, eb.w);
            chk("b_frame_done", 72'(b_fd), 72'(eb.fd));
         end
      end else if (b_fd === 1'b1) begin
         total++;
         bad++;
         $display("FAIL b_lone_frame_done got=1 want=0");
      end
   end

   initial begin
      int c0;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_a_win", a_win, 72'(0));
      chk("rst_a_flags", 72'({a_wv, a_fd}), 72'(0));
      chk("rst_b_win", b_win, 72'(0));
      chk("rst_b_flags", 72'({b_wv, b_fd}), 72'(0));

      // Continuous frame
      c0 = a_cnt;
      push_frame_a(8'h00);
      frame_a(8'h00, 1'b1, "s1");
      idle_a(2);
      chk("s1_count", 72'(a_cnt - c0), 72'(4));

      // Three idle cycles after pixel 10
      c0 = a_cnt;
      push_frame_a(8'h00);
      for (int k = 0; k < 16; k++) begin
         send_a(1'b1, k == 0, 8'(16 * (k / 4) + (k % 4)));
         if (k == 10) begin
            for (int j = 0; j < 3; j++) begin
               send_a(1'b0, 1'b0, 8'hee);
               chk("s2_idle_wv", 72'(a_wv), 72'(0));
               chk("s2_idle_hold", a_win, WT[0]);
            end
         end
      end
      idle_a(2);
      chk("s2_count", 72'(a_cnt - c0), 72'(4));

      // Back-to-back frames, second one offset by 0x80
      c0 = a_cnt;
      push_frame_a(8'h00);
      push_frame_a(8'h80);
      frame_a(8'h00, 1'b1, "s3a");
      frame_a(8'h80, 1'b0, "s3b");
      idle_a(2);
      chk("s3_count", 72'(a_cnt - c0), 72'(8));

      // frame_start with pixel 6 abandons the partial frame
      c0 = a_cnt;
      push_frame_a(8'h00);
      for (int k = 0; k < 6; k++) begin
         send_a(1'b1, k == 0, 8'(16 * (k / 4) + (k % 4)));
      end
      frame_a(8'h00, 1'b1, "s4");
      idle_a(2);
      chk("s4_count", 72'(a_cnt - c0), 72'(4));

      // Reset after pixel 11, then a fresh frame without frame_start
      c0 = a_cnt;
      push_a(WT[0], 1'b0);
      push_a(WT[1], 1'b0);
      for (int k = 0; k < 12; k++) begin
         send_a(1'b1, k == 0, 8'(16 * (k / 4) + (k % 4)));
      end
      do_reset();
      chk("s5_rst_win", a_win, 72'(0));
      chk("s5_rst_flags", 72'({a_wv, a_fd}), 72'(0));
      push_frame_a(8'h00);
      frame_a(8'h00, 1'b0, "s5");
      idle_a(2);
      chk("s5_count", 72'(a_cnt - c0), 72'(6));

      // 3x3 image yields a single window with frame_done
      c0 = b_cnt;
      eb.w  = WT[0];
      eb.fd = 1'b1;
      qb.push_back(eb);
      for (int k = 0; k < 9; k++) begin
         send_b(1'b1, k == 0, 8'(16 * (k / 3) + (k % 3)));
         if (k == 7) chk("s6_wv_before", 72'(b_wv), 72'(0));
      end
      chk("s6_wv_last", 72'(b_wv), 72'(1));
      send_b(1'b0, 1'b0, 8'h00);
      send_b(1'b0, 1'b0, 8'h00);
      chk("s6_count", 72'(b_cnt - c0), 72'(1));

      chk("a_queue_empty", 72'(qa.size()), 72'(0));
      chk("b_queue_empty", 72'(qb.size()), 72'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
